// File: rtl/alu_issue_scheduler_if.sv
// Bundle of reservation-station, ALU and CDB signals around the ALU issue scheduler.
// The scheduler uses the slave modport; the RS/ALU/arbiter environment uses master.
interface alu_issue_scheduler_if #(
  parameter int NUM_RS  = 3,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4,
  parameter int OP_W    = 2
);
  logic                      flush;
  logic [NUM_RS-1:0]         rsReady;
  logic [NUM_RS*OP_W-1:0]    rsOp;
  logic [NUM_RS*DATA_W-1:0]  rsData1;
  logic [NUM_RS*DATA_W-1:0]  rsData2;
  logic [NUM_RS*LABEL_W-1:0] rsLabel;
  logic [NUM_RS-1:0]         rsGrant;
  logic                      aluAvailable;
  logic                      aluWEN;
  logic [OP_W-1:0]           aluOp;
  logic [DATA_W-1:0]         aluData1;
  logic [DATA_W-1:0]         aluData2;
  logic [LABEL_W-1:0]        aluLabel;
  logic                      aluRequire;
  logic                      aluRequireAC;
  logic                      cdbReq;
  logic                      cdbAck;
  logic                      busy;
  logic [15:0]               issueCount;

  modport master (
    output flush, rsReady, rsOp, rsData1, rsData2, rsLabel,
           aluAvailable, aluRequire, cdbAck,
    input  rsGrant, aluWEN, aluOp, aluData1, aluData2, aluLabel,
           aluRequireAC, cdbReq, busy, issueCount
  );

  modport slave (
    input  flush, rsReady, rsOp, rsData1, rsData2, rsLabel,
           aluAvailable, aluRequire, cdbAck,
    output rsGrant, aluWEN, aluOp, aluData1, aluData2, aluLabel,
           aluRequireAC, cdbReq, busy, issueCount
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of ready RS entries into a one-entry register feeding the shared ALU,
// with pass-through of the ALU's CDB request/acknowledge handshake.
module alu_issue_scheduler #(
  parameter int NUM_RS  = 3,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4,
  parameter int OP_W    = 2
) (
  input  logic               clk,
  input  logic               RST,
  alu_issue_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_RS);

  logic               issue_valid_q, issue_valid_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  data1_q, data1_d;
  logic [DATA_W-1:0]  data2_q, data2_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [15:0]        issue_count_q, issue_count_d;

  logic               fire;
  logic               can_fill;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_RS-1:0]  grant_vec;

  // Arbitration: search upward from rr_ptr_q with wrap; the first ready entry wins.
  always_comb begin
    int idx;
    idx       = 0;
    fire      = issue_valid_q & bus.aluAvailable;
    can_fill  = ~bus.flush & ~RST & (~issue_valid_q | fire);
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_RS) idx = idx - NUM_RS;
      if (!grant_any && bus.rsReady[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (!can_fill) grant_any = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant_any && (grant_idx == PTR_W'(i))) grant_vec[i] = 1'b1;
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    rr_ptr_d      = rr_ptr_q;
    op_d          = op_q;
    data1_d       = data1_q;
    data2_d       = data2_q;
    label_d       = label_q;
    issue_count_d = issue_count_q + 16'(fire);
    if (bus.flush) begin
      issue_valid_d = 1'b0;
    end else if (grant_any) begin
      issue_valid_d = 1'b1;
      rr_ptr_d      = (grant_idx == PTR_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
    end else if (fire) begin
      issue_valid_d = 1'b0;
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant_vec[i]) begin
        op_d    = bus.rsOp[i*OP_W +: OP_W];
        data1_d = bus.rsData1[i*DATA_W +: DATA_W];
        data2_d = bus.rsData2[i*DATA_W +: DATA_W];
        label_d = bus.rsLabel[i*LABEL_W +: LABEL_W];
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      issue_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
      op_q          <= '0;
      data1_q       <= '0;
      data2_q       <= '0;
      label_q       <= '0;
      issue_count_q <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      op_q          <= op_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      label_q       <= label_d;
      issue_count_q <= issue_count_d;
    end
  end

  // CDB handshake is purely combinational; no latency is added.
  assign bus.rsGrant      = grant_vec;
  assign bus.aluWEN       = issue_valid_q;
  assign bus.aluOp        = op_q;
  assign bus.aluData1     = data1_q;
  assign bus.aluData2     = data2_q;
  assign bus.aluLabel     = label_q;
  assign bus.cdbReq       = bus.aluRequire;
  assign bus.aluRequireAC = bus.aluRequire & bus.cdbAck;
  assign bus.busy         = issue_valid_q | bus.aluRequire;
  assign bus.issueCount   = issue_count_q;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed vector table, reset-mid-op sequence,
// and randomized traffic against a transaction-level reference model.
module tb_alu_issue_scheduler;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int OW = 2;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  alu_issue_scheduler_if #(.NUM_RS(N), .DATA_W(DW), .LABEL_W(LW), .OP_W(OW)) bus ();

  alu_issue_scheduler #(.NUM_RS(N), .DATA_W(DW), .LABEL_W(LW), .OP_W(OW)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        flush;
    logic [2:0]  rdy;
    logic        avail;
    logic        req;
    logic        ack;
    logic [2:0]  grant;
    logic        wen;
    logic [3:0]  lbl;
    logic        ac;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  // Reference model state
  logic          m_valid;
  int            m_ptr;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_d1, m_d2;
  logic [LW-1:0] m_lbl;
  int            m_cnt;

  task automatic set_fixed_entries();
    for (int i = 0; i < N; i++) begin
      bus.rsOp[i*OW +: OW]    = OW'(i);
      bus.rsData1[i*DW +: DW] = DW'(5 + 16 * i);
      bus.rsData2[i*DW +: DW] = DW'(7 + 16 * i);
      bus.rsLabel[i*LW +: LW] = LW'(3 + i);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ptr = 0; m_op = '0; m_d1 = '0; m_d2 = '0; m_lbl = '0; m_cnt = 0;
  endtask

  // Checks current outputs against the model, then advances the model across the edge.
  task automatic model_check_and_step();
    logic       fire, fill;
    int         win;
    logic [N-1:0] exp_g;
    fire  = m_valid & bus.aluAvailable;
    fill  = !bus.flush && (!m_valid || fire);
    win   = -1;
    exp_g = '0;
    for (int k = 0; k < N; k++) begin
      if (win < 0 && bus.rsReady[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    if (fill && win >= 0) exp_g[win] = 1'b1;
    chk("rnd_grant", 64'(bus.rsGrant), 64'(exp_g));
    chk("rnd_wen",   64'(bus.aluWEN), 64'(m_valid));
    chk("rnd_op",    64'(bus.aluOp), 64'(m_op));
    chk("rnd_d1",    64'(bus.aluData1), 64'(m_d1));
    chk("rnd_d2",    64'(bus.aluData2), 64'(m_d2));
    chk("rnd_lbl",   64'(bus.aluLabel), 64'(m_lbl));
    chk("rnd_cnt",   64'(bus.issueCount), 64'(m_cnt % 65536));
    chk("rnd_ac",    64'(bus.aluRequireAC), 64'(bus.aluRequire && bus.cdbAck));
    chk("rnd_cdbreq", 64'(bus.cdbReq), 64'(bus.aluRequire));
    chk("rnd_busy",  64'(bus.busy), 64'(m_valid || bus.aluRequire));
    if (fire) m_cnt++;
    if (fill && win >= 0) begin
      m_op  = bus.rsOp[win*OW +: OW];
      m_d1  = bus.rsData1[win*DW +: DW];
      m_d2  = bus.rsData2[win*DW +: DW];
      m_lbl = bus.rsLabel[win*LW +: LW];
      m_valid = 1'b1;
      m_ptr = (win + 1) % N;
    end else if (bus.flush || fire) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    // flush rdy avail req ack | grant wen lbl ac busy cnt
    tbl[0]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 16'd0};
    tbl[2]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 4'd5, 1'b0, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 4'd3, 1'b0, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 4'd4, 1'b0, 1'b1, 16'd3};
    tbl[7]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 4'd5, 1'b0, 1'b1, 16'd4};
    tbl[8]  = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 16'd5};
    tbl[9]  = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 16'd5};
    tbl[10] = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 16'd5};
    tbl[11] = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 16'd5};
    tbl[12] = '{1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 4'd3, 1'b0, 1'b1, 16'd5};
    tbl[13] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 4'd4, 1'b0, 1'b1, 16'd6};
    tbl[14] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 16'd6};
    tbl[15] = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 4'd0, 1'b0, 1'b0, 16'd6};
    tbl[16] = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 4'd5, 1'b0, 1'b1, 16'd6};
    tbl[17] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 16'd7};
    tbl[18] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b1, 16'd7};
    tbl[19] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b1, 16'd7};
    tbl[20] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 4'd0, 1'b1, 1'b1, 16'd7};
    tbl[21] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 16'd7};

    bus.flush = 1'b0; bus.rsReady = '0; bus.aluAvailable = 1'b0;
    bus.aluRequire = 1'b0; bus.cdbAck = 1'b0;
    set_fixed_entries();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen",   64'(bus.aluWEN), 64'd0);
    chk("reset_cnt",   64'(bus.issueCount), 64'd0);
    chk("reset_op",    64'(bus.aluOp), 64'd0);
    chk("reset_d1",    64'(bus.aluData1), 64'd0);
    chk("reset_lbl",   64'(bus.aluLabel), 64'd0);
    chk("reset_grant", 64'(bus.rsGrant), 64'd0);
    RST = 1'b0;
    next_cycle();

    for (int r = 0; r < NV; r++) begin
      bus.flush = tbl[r].flush; bus.rsReady = tbl[r].rdy; bus.aluAvailable = tbl[r].avail;
      bus.aluRequire = tbl[r].req; bus.cdbAck = tbl[r].ack;
      #4;
      chk($sformatf("v%0d_grant", r), 64'(bus.rsGrant), 64'(tbl[r].grant));
      chk($sformatf("v%0d_wen", r),   64'(bus.aluWEN), 64'(tbl[r].wen));
      chk($sformatf("v%0d_ac", r),    64'(bus.aluRequireAC), 64'(tbl[r].ac));
      chk($sformatf("v%0d_cdbreq", r), 64'(bus.cdbReq), 64'(tbl[r].req));
      chk($sformatf("v%0d_busy", r),  64'(bus.busy), 64'(tbl[r].busy));
      chk($sformatf("v%0d_cnt", r),   64'(bus.issueCount), 64'(tbl[r].cnt));
      if (tbl[r].wen) begin
        idx = int'(tbl[r].lbl) - 3;
        chk($sformatf("v%0d_lbl", r), 64'(bus.aluLabel), 64'(tbl[r].lbl));
        chk($sformatf("v%0d_op", r),  64'(bus.aluOp), 64'(idx));
        chk($sformatf("v%0d_d1", r),  64'(bus.aluData1), 64'(5 + 16 * idx));
        chk($sformatf("v%0d_d2", r),  64'(bus.aluData2), 64'(7 + 16 * idx));
      end
      next_cycle();
    end

    // Reset while an op is held and the pointer sits at 2
    bus.flush = 1'b0; bus.rsReady = 3'b010; bus.aluAvailable = 1'b0;
    bus.aluRequire = 1'b0; bus.cdbAck = 1'b0;
    #4;
    chk("rm_grant1", 64'(bus.rsGrant), 64'b010);
    next_cycle();
    bus.rsReady = 3'b111;
    #1;
    chk("rm_held_wen", 64'(bus.aluWEN), 64'd1);
    chk("rm_held_lbl", 64'(bus.aluLabel), 64'd4);
    #1;
    RST = 1'b1;
    #1;
    chk("rm_wen",   64'(bus.aluWEN), 64'd0);
    chk("rm_op",    64'(bus.aluOp), 64'd0);
    chk("rm_d1",    64'(bus.aluData1), 64'd0);
    chk("rm_d2",    64'(bus.aluData2), 64'd0);
    chk("rm_lbl",   64'(bus.aluLabel), 64'd0);
    chk("rm_cnt",   64'(bus.issueCount), 64'd0);
    chk("rm_grant", 64'(bus.rsGrant), 64'd0);
    chk("rm_busy",  64'(bus.busy), 64'd0);
    next_cycle();
    RST = 1'b0;
    bus.aluAvailable = 1'b1;
    #3;
    chk("rm_after_grant", 64'(bus.rsGrant), 64'b001);
    next_cycle();

    // Randomized traffic against the reference model
    RST = 1'b1;
    bus.rsReady = '0;
    next_cycle();
    RST = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bus.flush        = (($urandom % 8) == 0);
      bus.rsReady      = N'($urandom);
      bus.aluAvailable = (($urandom % 4) != 0);
      bus.aluRequire   = $urandom % 2;
      bus.cdbAck       = $urandom % 2;
      for (int i = 0; i < N; i++) begin
        bus.rsOp[i*OW +: OW]    = OW'($urandom);
        bus.rsData1[i*DW +: DW] = $urandom;
        bus.rsData2[i*DW +: DW] = $urandom;
        bus.rsLabel[i*LW +: LW] = LW'($urandom);
      end
      #4;
      model_check_and_step();
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
